// File: rtl/controller_responder.sv
// Device-side serial game-controller pad: latches a button vector on the host latch pulse
// and shifts it out MSB-first on an active-low data line, one bit per host clock rise.
module controller_responder #(
    parameter int NUM_BITS       = 8,
    parameter int FILL_LEVEL     = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          rst_B,
    input  logic                          controller_latch,
    input  logic                          controller_clk,
    input  logic [NUM_BITS-1:0]           buttons,
    output logic                          controller_data_out_B,
    output logic                          frame_done,
    output logic                          busy,
    output logic [$clog2(NUM_BITS+1)-1:0] bit_index
);

    // state | meaning
    // IDLE  | no frame, line parked high, waiting for latch rise
    // LOAD  | latch held, shift register tracks ~buttons
    // SHIFT | shifting one bit per host clock rise, timeout armed
    // DONE  | frame consumed, extra clocks shift FILL_LEVEL
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam int   BW   = $clog2(NUM_BITS + 1);
    localparam int   TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic FILL = (FILL_LEVEL != 0);

    state_t              state, state_next;
    logic [NUM_BITS-1:0] sr, sr_next, sr_shifted;
    logic [NUM_BITS-1:0] btn_s1, btn_s2;
    logic [BW-1:0]       idx_next;
    logic [TW-1:0]       tmo, tmo_next;
    logic                done_next, data_next, busy_next;
    logic                latch_s1, latch_s2, latch_h;
    logic                cclk_s1, cclk_s2, cclk_h;
    logic                latch_rise, latch_fall, cclk_rise;

    // Buttons are asynchronous too, so they get the same two-flop treatment.
    always_ff @(posedge clk or negedge rst_B) begin
        if (!rst_B) begin
            latch_s1 <= 1'b0;
            latch_s2 <= 1'b0;
            latch_h  <= 1'b0;
            cclk_s1  <= 1'b0;
            cclk_s2  <= 1'b0;
            cclk_h   <= 1'b0;
            btn_s1   <= '0;
            btn_s2   <= '0;
        end else begin
            latch_s1 <= controller_latch;
            latch_s2 <= latch_s1;
            latch_h  <= latch_s2;
            cclk_s1  <= controller_clk;
            cclk_s2  <= cclk_s1;
            cclk_h   <= cclk_s2;
            btn_s1   <= buttons;
            btn_s2   <= btn_s1;
        end
    end

    assign latch_rise = latch_s2 & ~latch_h;
    assign latch_fall = ~latch_s2 & latch_h;
    assign cclk_rise  = cclk_s2 & ~cclk_h;
    assign sr_shifted = (sr << 1) | NUM_BITS'(FILL);

    always_comb begin
        state_next = state;
        sr_next    = sr;
        idx_next   = bit_index;
        tmo_next   = tmo;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (latch_rise) begin
                    state_next = LOAD;
                    sr_next    = ~btn_s2;
                    idx_next   = '0;
                    tmo_next   = '0;
                end
            end
            LOAD: begin
                if (latch_fall) begin
                    state_next = SHIFT;
                end else if (latch_s2) begin
                    sr_next  = ~btn_s2;
                    idx_next = '0;
                    tmo_next = '0;
                end
            end
            SHIFT: begin
                if (latch_rise) begin
                    state_next = LOAD;
                    sr_next    = ~btn_s2;
                    idx_next   = '0;
                    tmo_next   = '0;
                end else if (cclk_rise) begin
                    sr_next  = sr_shifted;
                    idx_next = bit_index + BW'(1);
                    tmo_next = '0;
                    if (bit_index == BW'(NUM_BITS - 1)) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    tmo_next   = '0;
                end else begin
                    tmo_next = tmo + TW'(1);
                end
            end
            DONE: begin
                if (latch_rise) begin
                    state_next = LOAD;
                    sr_next    = ~btn_s2;
                    idx_next   = '0;
                    tmo_next   = '0;
                end else if (cclk_rise) begin
                    sr_next = sr_shifted;
                    if (bit_index != BW'(NUM_BITS))
                        idx_next = bit_index + BW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        data_next = (state_next == IDLE) ? 1'b1 : sr_next[NUM_BITS-1];
        busy_next = (state_next == LOAD) || (state_next == SHIFT);
    end

    always_ff @(posedge clk or negedge rst_B) begin
        if (!rst_B) begin
            state                 <= IDLE;
            sr                    <= {NUM_BITS{FILL}};
            bit_index             <= '0;
            tmo                   <= '0;
            frame_done            <= 1'b0;
            busy                  <= 1'b0;
            controller_data_out_B <= 1'b1;
        end else begin
            state                 <= state_next;
            sr                    <= sr_next;
            bit_index             <= idx_next;
            tmo                   <= tmo_next;
            frame_done            <= done_next;
            busy                  <= busy_next;
            controller_data_out_B <= data_next;
        end
    end

endmodule
